// File: rtl/mac_seq.sv
// Handshaked sequential MAC: Y_k = (hi(A_k*X_k) + Y_{k-1}) >> 1 over up to MAX_LEN pairs.
// Define MAC_SEQ_ROUND_EN for round-to-nearest at the product and accumulate truncations.
module mac_seq #(
   parameter int N       = 32,
   parameter int MAX_LEN = 16,
   parameter int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic [N-1:0]  y0,
   output logic          busy,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  x,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  y
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [N-1:0]  p_q, p_d;
   logic [N-1:0]  y_q, y_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          pv_q, pv_d;
   logic          busy_q, busy_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   logic          accept;
   logic [LW-1:0] len_clamped;
   logic [2*N-1:0] prod;
   logic [N:0]    sum;

   always_comb begin
      len_clamped = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
      accept      = (state_q == RUN) && in_ready_q && in_valid;
`ifdef MAC_SEQ_ROUND_EN
      prod = ({{N{1'b0}}, a} * {{N{1'b0}}, x}) + {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
      sum  = {1'b0, p_q} + {1'b0, acc_q} + (N+1)'(1);
`else
      prod = {{N{1'b0}}, a} * {{N{1'b0}}, x};
      sum  = {1'b0, p_q} + {1'b0, acc_q};
`endif

      state_d = state_q;
      acc_d   = acc_q;
      p_d     = p_q;
      rem_d   = rem_q;
      pv_d    = pv_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = y0;
               rem_d   = len_clamped;
               pv_d    = 1'b0;
               state_d = (len_clamped != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (accept) begin
               rem_d = rem_q - LW'(1);
               p_d   = N'(prod >> N);
               pv_d  = 1'b1;
            end else begin
               pv_d  = 1'b0;
            end
            if (pv_q) acc_d = N'(sum >> 1);
            // Leave only once the last product has been folded into acc.
            if ((rem_q == '0) && !pv_q && !accept) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d      = (state_d != IDLE);
      in_ready_d  = (state_d == RUN) && (rem_d != '0);
      out_valid_d = (state_d == DONE);
      y_d         = (state_d == DONE) ? acc_d : y_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         p_q         <= '0;
         y_q         <= '0;
         rem_q       <= '0;
         pv_q        <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         p_q         <= p_d;
         y_q         <= y_d;
         rem_q       <= rem_d;
         pv_q        <= pv_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy      = busy_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = y_q;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq against a job-level arithmetic model of the recurrence.
// Honours MAC_SEQ_ROUND_EN the same way the design does.
module tb_mac_seq;
   localparam int N       = 32;
   localparam int MAX_LEN = 16;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic [N-1:0]  y0 = '0;
   logic          busy;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  a = '0;
   logic [N-1:0]  x = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  y;

   int checks = 0;
   int errors = 0;

   logic [31:0] pa[$];
   logic [31:0] px[$];

   mac_seq #(.N(N), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .y0(y0), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .x(x),
      .out_valid(out_valid), .out_ready(out_ready), .y(y)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Fold every accepted pair, in order, into the seed using plain 64-bit arithmetic.
   function automatic logic [31:0] model_result(input logic [31:0] seed);
      longint unsigned yv, prod, hi;
      yv = 64'(seed);
      foreach (pa[i]) begin
         prod = 64'(pa[i]) * 64'(px[i]);
`ifdef MAC_SEQ_ROUND_EN
         prod = prod + 64'h8000_0000;
         hi   = prod >> 32;
         yv   = (hi + yv + 1) >> 1;
`else
         hi   = prod >> 32;
         yv   = (hi + yv) >> 1;
`endif
      end
      return yv[31:0];
   endfunction

   function automatic int exp_pairs(input int l);
      return (l > MAX_LEN) ? MAX_LEN : l;
   endfunction

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Starts a job from IDLE and feeds pairs until out_valid; edge 0 is the start edge.
   task automatic run_job(input int len_i, input logic [31:0] y0_i, input int mode,
                          input bit fixed, input logic [31:0] fa, input logic [31:0] fx,
                          output logic [31:0] y_got, output int nacc, output int ready_cycles,
                          output int last_acc_edge, output int valid_edge, output bit timeout);
      pa.delete();
      px.delete();
      nacc = 0; ready_cycles = 0; last_acc_edge = -1; valid_edge = -1;
      timeout = 1'b1; y_got = '0;
      start = 1'b1; len = LW'(len_i); y0 = y0_i; in_valid = 1'b0;
      step();
      start = 1'b0;
      for (int e = 1; e <= 300; e++) begin
         if (out_valid) begin
            valid_edge = e - 1;
            timeout    = 1'b0;
            y_got      = y;
            break;
         end
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (e % 2 == 1);
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         a = fixed ? fa : $urandom();
         x = fixed ? fx : $urandom();
         if (in_ready) ready_cycles++;
         if (in_valid && in_ready) begin
            pa.push_back(a);
            px.push_back(x);
            nacc++;
            last_acc_edge = e;
         end
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_job();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got busy/in_ready/out_valid=%b expected 000", {busy, in_ready, out_valid});
      end
      checks++;
      if (y !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_y: got %h expected 00000000", y);
      end
   endtask

   task automatic test_full_scale();
      logic [31:0] yg; int na, rc, la, ve; bit to;
      do_reset();
      run_job(1, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, yg, na, rc, la, ve, to);
      checks++;
      if (to || yg !== 32'h7FFF_FFFF) begin
         errors++;
         $display("[TB] FAIL full_scale_y: got %h (timeout=%0d) expected 7fffffff", yg, to);
      end
      checks++;
      if (ve - la !== 2) begin
         errors++;
         $display("[TB] FAIL full_scale_latency: got %0d edges expected 2", ve - la);
      end
      finish_job();
   endtask

   task automatic test_len3_fixed();
      logic [31:0] yg; int na, rc, la, ve; bit to;
      do_reset();
      run_job(3, 32'h4000_0000, 0, 1'b1, 32'h8000_0000, 32'h8000_0000, yg, na, rc, la, ve, to);
      checks++;
      if (to || yg !== 32'h4000_0000) begin
         errors++;
         $display("[TB] FAIL len3_y: got %h (timeout=%0d) expected 40000000", yg, to);
      end
      checks++;
      if (na !== 3) begin
         errors++;
         $display("[TB] FAIL len3_accepts: got %0d expected 3", na);
      end
      checks++;
      if (rc !== 3) begin
         errors++;
         $display("[TB] FAIL len3_ready_cycles: got %0d expected 3", rc);
      end
      finish_job();
   endtask

   task automatic test_rounding();
      logic [31:0] yg, exp_y; int na, rc, la, ve; bit to;
`ifdef MAC_SEQ_ROUND_EN
      exp_y = 32'h0000_0001;
`else
      exp_y = 32'h0000_0000;
`endif
      do_reset();
      run_job(1, 32'h0000_0001, 0, 1'b1, 32'h0, 32'h0, yg, na, rc, la, ve, to);
      checks++;
      if (to || yg !== exp_y) begin
         errors++;
         $display("[TB] FAIL rounding_y: got %h (timeout=%0d) expected %h", yg, to, exp_y);
      end
      finish_job();
   endtask

   task automatic test_len_zero();
      logic [31:0] yg; int na, rc, la, ve; bit to;
      do_reset();
      run_job(0, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 32'h0, yg, na, rc, la, ve, to);
      checks++;
      if (to || yg !== 32'hDEAD_BEEF || ve !== 0) begin
         errors++;
         $display("[TB] FAIL len0_y: got %h at edge %0d (timeout=%0d) expected deadbeef at edge 0", yg, ve, to);
      end
      // Hold the result while start pulses arrive; neither may disturb it.
      for (int i = 0; i < 5; i++) begin
         start = 1'($urandom_range(0, 1)); len = LW'(3); y0 = $urandom();
         step();
         checks++;
         if ({out_valid, busy, in_ready, y} !== {3'b110, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL len0_hold: got ov/busy/ir=%b y=%h expected 110 deadbeef", {out_valid, busy, in_ready}, y);
         end
      end
      start = 1'b0;
      finish_job();
      step();
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL len0_release: got ov/busy/ir=%b expected 000", {out_valid, busy, in_ready});
      end
   endtask

   task automatic test_bubbles_and_abort();
      logic [31:0] yg, exp_y, seed; int na, rc, la, ve; bit to; int cnt;
      do_reset();
      seed = $urandom();
      run_job(4, seed, 1, 1'b0, 32'h0, 32'h0, yg, na, rc, la, ve, to);
      exp_y = model_result(seed);
      checks++;
      if (to || na !== 4 || yg !== exp_y) begin
         errors++;
         $display("[TB] FAIL bubbles_y: got %h after %0d pairs (timeout=%0d) expected %h after 4", yg, na, to, exp_y);
      end
      finish_job();
      // Abort a job after two accepted pairs.
      start = 1'b1; len = LW'(4); y0 = $urandom();
      step();
      start = 1'b0;
      cnt = 0;
      for (int e = 1; e <= 50 && cnt < 2; e++) begin
         in_valid = (e % 2 == 1);
         a = $urandom(); x = $urandom();
         if (in_valid && in_ready) cnt++;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      checks++;
      if ({busy, in_ready, out_valid, y} !== {3'b000, 32'h0} || cnt !== 2) begin
         errors++;
         $display("[TB] FAIL abort_reset: got ctrl=%b y=%h accepts=%0d expected 000 00000000 accepts=2", {busy, in_ready, out_valid}, y, cnt);
      end
      rst = 1'b0;
      seed = $urandom();
      run_job(5, seed, 2, 1'b0, 32'h0, 32'h0, yg, na, rc, la, ve, to);
      exp_y = model_result(seed);
      checks++;
      if (to || na !== 5 || yg !== exp_y) begin
         errors++;
         $display("[TB] FAIL after_abort_y: got %h after %0d pairs (timeout=%0d) expected %h after 5", yg, na, to, exp_y);
      end
      finish_job();
   endtask

   task automatic test_clamp();
      logic [31:0] yg, exp_y, seed; int na, rc, la, ve; bit to;
      do_reset();
      seed = $urandom();
      run_job(20, seed, 0, 1'b0, 32'h0, 32'h0, yg, na, rc, la, ve, to);
      exp_y = model_result(seed);
      checks++;
      if (na !== 16) begin
         errors++;
         $display("[TB] FAIL clamp_accepts: got %0d expected 16", na);
      end
      checks++;
      if (to || yg !== exp_y) begin
         errors++;
         $display("[TB] FAIL clamp_y: got %h (timeout=%0d) expected %h", yg, to, exp_y);
      end
      finish_job();
   endtask

   task automatic test_back_to_back();
      logic [31:0] yg, exp_y, seed; int na, rc, la, ve, l; bit to;
      do_reset();
      for (int j = 0; j < 6; j++) begin
         l = (j == 0) ? 0 : $urandom_range(0, 18);
         seed = $urandom();
         run_job(l, seed, (j % 2 == 0) ? 0 : 2, 1'b0, 32'h0, 32'h0, yg, na, rc, la, ve, to);
         exp_y = model_result(seed);
         checks++;
         if (to || na !== exp_pairs(l) || yg !== exp_y) begin
            errors++;
            $display("[TB] FAIL b2b_job%0d: got %h after %0d pairs (timeout=%0d) expected %h after %0d", j, yg, na, to, exp_y, exp_pairs(l));
         end
         finish_job();
      end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_len3_fixed();
      test_rounding();
      test_len_zero();
      test_bubbles_and_abort();
      test_clamp();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
